timer_ctrl16: RTL and testbench

TIMER_CTRL16 -- requirements
Module: timer_ctrl16

---
 rtl/timer_ctrl16.sv | 171 +++++++++++++++++
 tb/tb_timer_ctrl16.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl16.sv
// timer_ctrl16: control FSM for an external 16-bit up/down counter.
// Button rising edges request load / start-resume / pause-abort; a
// prescaler paces count steps while running, and the controller stops at the
// counter's terminal value instead of letting it wrap.
// Optional build macro TIMER_CTRL16_AUTORELOAD_EN: a down-count that reaches
// zero reloads the captured value and keeps running (if that value is non-zero).
//
// Request semantics: each button is a level; a request is the single cycle in
// which the level is 1 and its registered copy is still 0. The FSM acts on it
// at the next rising edge, where state and the registered counter controls
// change together. Priority when requests coincide: load > stop > start.
module timer_ctrl16 #(
  parameter int PRESCALE = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        btn_load_i,
  input  logic        btn_start_i,
  input  logic        btn_stop_i,
  input  logic        dir_i,
  input  logic [15:0] sw_i,
  input  logic [15:0] q_i,
  input  logic        utc_i,
  input  logic        dtc_i,
  output logic        up_o,
  output logic        dw_o,
  output logic        ld_o,
  output logic [15:0] din_o,
  output logic [2:0]  state_o,
  output logic        done_o
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic          load_d, start_d, stop_d;
  logic          load_req, start_req, stop_req;
  logic [CW-1:0] cnt;
  logic          dir_r;
  logic          tick, at_term, reload_hit, run_go;
  logic          up_nx, dw_nx, ld_nx;
  logic [15:0]   din_nx;

  // The counter value is observation only; decisions use the flags.
  logic unused_q;
  assign unused_q = ^q_i;

  // Button edge registers; reset to 1 so a button held through reset is not a request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      load_d  <= 1'b1;
      start_d <= 1'b1;
      stop_d  <= 1'b1;
    end else begin
      load_d  <= btn_load_i;
      start_d <= btn_start_i;
      stop_d  <= btn_stop_i;
    end
  end

  assign load_req  = btn_load_i  & ~load_d;
  assign stop_req  = btn_stop_i  & ~stop_d;
  assign start_req = btn_start_i & ~start_d;

  assign tick    = (state == S_RUN) && (cnt == LAST);
  assign at_term = dir_r ? utc_i : dtc_i;
  // A tick is acted on only if no higher-priority request pre-empts it.
  assign run_go  = tick && !load_req && !stop_req;

`ifdef TIMER_CTRL16_AUTORELOAD_EN
  logic [15:0] reload_r;

  // Reload value captured on every load.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)       reload_r <= 16'h0000;
    else if (load_req) reload_r <= sw_i;
  end

  assign reload_hit = !dir_r && dtc_i && (reload_r != 16'h0000);
`else
  assign reload_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; load pre-empts everything.
  always_comb begin
    state_nx = state;
    if (load_req) begin
      state_nx = S_LOAD;
    end else begin
      case (state)
        S_LOAD:  state_nx = S_IDLE;
        S_IDLE:  if (start_req) state_nx = S_RUN;
        S_RUN: begin
          if (stop_req)                           state_nx = S_PAUSE;
          else if (tick && at_term && !reload_hit) state_nx = S_DONE;
        end
        S_PAUSE: begin
          if (stop_req)       state_nx = S_IDLE;
          else if (start_req) state_nx = S_RUN;
        end
        S_DONE:  if (stop_req) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Next values of the registered counter controls; up/dw/ld never coincide.
  always_comb begin
    up_nx  = run_go && dir_r && !utc_i;
    dw_nx  = run_go && !dir_r && !dtc_i;
    ld_nx  = 1'b0;
    din_nx = din_o;
    if (load_req) begin
      ld_nx  = 1'b1;
      din_nx = sw_i;
    end else if (run_go && at_term && reload_hit) begin
      ld_nx  = 1'b1;
`ifdef TIMER_CTRL16_AUTORELOAD_EN
      din_nx = reload_r;
`endif
    end
  end

  // Registered outputs, prescaler and latched direction.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      up_o  <= 1'b0;
      dw_o  <= 1'b0;
      ld_o  <= 1'b0;
      din_o <= 16'h0000;
      cnt   <= '0;
      dir_r <= 1'b0;
    end else begin
      up_o  <= up_nx;
      dw_o  <= dw_nx;
      ld_o  <= ld_nx;
      din_o <= din_nx;
      // Prescaler runs only while staying in RUN; any entry starts from zero.
      if (state == S_RUN && state_nx == S_RUN && !tick) cnt <= cnt + CW'(1);
      else                                              cnt <= '0;
      if ((state == S_IDLE || state == S_PAUSE) && state_nx == S_RUN)
        dir_r <= dir_i;
    end
  end

  // Encoded state for observation; unused codes read as IDLE.
  always_comb begin
    case (state)
      S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE: state_o = state;
      default:                                state_o = 3'd0;
    endcase
  end

  assign done_o = (state == S_DONE);

endmodule

// File: tb/tb_timer_ctrl16.sv
// Directed bench for timer_ctrl16 with PRESCALE=4 and a behavioural 16-bit
// up/down counter closing the loop (q, utc, dtc fed back to the controller).
module tb_timer_ctrl16;

  logic        clk;
  logic        rst_n;
  logic        btn_load, btn_start, btn_stop, dir;
  logic [15:0] sw;
  logic [15:0] q;
  logic        utc, dtc;
  logic        up, dw, ld, done;
  logic [15:0] din;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  timer_ctrl16 #(.PRESCALE(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .btn_load_i (btn_load),
    .btn_start_i(btn_start),
    .btn_stop_i (btn_stop),
    .dir_i      (dir),
    .sw_i       (sw),
    .q_i        (q),
    .utc_i      (utc),
    .dtc_i      (dtc),
    .up_o       (up),
    .dw_o       (dw),
    .ld_o       (ld),
    .din_o      (din),
    .state_o    (state),
    .done_o     (done)
  );

  // External counter model
  always @(posedge clk) begin
    if (!rst_n)  q <= 16'h0000;
    else if (ld) q <= din;
    else if (up) q <= q + 16'h0001;
    else if (dw) q <= q - 16'h0001;
  end
  assign utc = (q == 16'hFFFF);
  assign dtc = (q == 16'h0000);

  // Driver tasks
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic l, input logic s, input logic t);
    btn_load = l; btn_stop = s; btn_start = t;
    step();
    btn_load = 1'b0; btn_stop = 1'b0; btn_start = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; btn_load = 1'b0; btn_start = 1'b1; btn_stop = 1'b0;
    dir = 1'b0; sw = 16'h0000;
    step(3);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_up",    16'(up),    16'd0);
    chk("rst_dw",    16'(dw),    16'd0);
    chk("rst_ld",    16'(ld),    16'd0);
    chk("rst_done",  16'(done),  16'd0);
    chk("rst_din",   din,        16'h0000);
    // start held through reset release is not a request
    rst_n = 1'b1;
    step(3);
    chk("held_start_state", 16'(state), 16'd0);
    btn_start = 1'b0;
    step();

    // Load 3
    sw = 16'h0003;
    pulse(1'b1, 1'b0, 1'b0);
    chk("load_state", 16'(state), 16'd1);
    chk("load_ld",    16'(ld),    16'd1);
    chk("load_din",   din,        16'h0003);
    step();
    chk("load_idle",  16'(state), 16'd0);
    chk("load_ld_end",16'(ld),    16'd0);
    chk("load_q",     q,          16'h0003);

    // Count down from 3, pulses 4 cycles apart
    dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    chk("dn_run", 16'(state), 16'd2);
    for (int i = 0; i < 3; i++) begin
      step(3);
      chk("dn_gap", 16'(dw), 16'd0);
      step();
      chk("dn_pulse", 16'(dw), 16'd1);
      chk("dn_up_excl", 16'(up), 16'd0);
      chk("dn_q_before", q, 16'(3 - i));
    end
    step(3);
    chk("dn_q_zero", q, 16'h0000);
    chk("dn_run_at0", 16'(state), 16'd2);
    step();
    chk("dn_no_wrap_dw", 16'(dw), 16'd0);
`ifdef TIMER_CTRL16_AUTORELOAD_EN
    chk("ar_state", 16'(state), 16'd2);
    chk("ar_ld",    16'(ld),    16'd1);
    chk("ar_din",   din,        16'h0003);
    pulse(1'b0, 1'b1, 1'b0);
    chk("ar_pause", 16'(state), 16'd3);
    pulse(1'b0, 1'b1, 1'b0);
    chk("ar_idle",  16'(state), 16'd0);
`else
    chk("dn_done_state", 16'(state), 16'd4);
    chk("dn_done_o",     16'(done),  16'd1);
    step(2);
    chk("dn_q_stays0", q, 16'h0000);
    pulse(1'b0, 1'b0, 1'b1);
    chk("done_start_ign", 16'(state), 16'd4);
    step();
    pulse(1'b0, 1'b1, 1'b0);
    chk("done_stop_idle", 16'(state), 16'd0);
    chk("done_o_clear",   16'(done),  16'd0);
`endif
    step();

    // Count up from 0xFFFE: one step then DONE, no wrap
    sw = 16'hFFFE;
    pulse(1'b1, 1'b0, 1'b0);
    step();
    chk("up_load_q", q, 16'hFFFE);
    dir = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    step(3);
    chk("up_gap", 16'(up), 16'd0);
    step();
    chk("up_pulse", 16'(up), 16'd1);
    step();
    chk("up_q_max", q, 16'hFFFF);
    step(3);
    chk("up_done_state", 16'(state), 16'd4);
    chk("up_no_step",    16'(up),    16'd0);
    step(4);
    chk("up_no_wrap", q, 16'hFFFF);
    pulse(1'b0, 1'b1, 1'b0);
    chk("up_stop_idle", 16'(state), 16'd0);
    step();

    // Pause on a tick cycle, then resume
    sw = 16'h0010;
    pulse(1'b1, 1'b0, 1'b0);
    step();
    dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    step(3);
    pulse(1'b0, 1'b1, 1'b0);
    chk("pause_state", 16'(state), 16'd3);
    chk("pause_no_dw", 16'(dw),    16'd0);
    step(3);
    chk("pause_q_held", q, 16'h0010);
    pulse(1'b0, 1'b0, 1'b1);
    chk("resume_state", 16'(state), 16'd2);
    step(3);
    chk("resume_gap", 16'(dw), 16'd0);
    step();
    chk("resume_pulse", 16'(dw), 16'd1);

    // Load, stop and start together on a tick cycle: load wins
    sw = 16'h0042;
    step(3);
    pulse(1'b1, 1'b1, 1'b1);
    chk("prio_state", 16'(state), 16'd1);
    chk("prio_ld",    16'(ld),    16'd1);
    chk("prio_dw",    16'(dw),    16'd0);
    chk("prio_up",    16'(up),    16'd0);
    chk("prio_din",   din,        16'h0042);
    step();
    chk("prio_idle",  16'(state), 16'd0);
    chk("prio_q",     q,          16'h0042);

    // Reset mid-RUN just before a tick: no step pulse
    sw = 16'h0005;
    pulse(1'b1, 1'b0, 1'b0);
    step();
    dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    step(3);
    rst_n = 1'b0;
    step();
    chk("rrun_dw",    16'(dw),    16'd0);
    chk("rrun_state", 16'(state), 16'd0);
    rst_n = 1'b1;
    step();
    chk("rrun_dw2",   16'(dw),    16'd0);
    chk("rrun_idle",  16'(state), 16'd0);
    step(4);
    chk("rrun_stays", 16'(state), 16'd0);

`ifdef TIMER_CTRL16_AUTORELOAD_EN
    // Autoreload from 2: q sequence 2,1,0,2,1,0 staying in RUN
    sw = 16'h0002;
    pulse(1'b1, 1'b0, 1'b0);
    step();
    dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(4);
      chk("arl_state", 16'(state), 16'd2);
      chk("arl_q", q, 16'(2 - (i % 3)));
      if (i % 3 == 2) begin
        chk("arl_ld",  16'(ld), 16'd1);
        chk("arl_din", din,     16'h0002);
      end else begin
        chk("arl_dw",  16'(dw), 16'd1);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
